// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: frame-synchronous snapshot, erase pass and draw pass feeding the rectangle engine.
// Optional erase pass and old-snapshot registers are built only when DRAW_ERASE_EN is defined.
module frame_draw_scheduler #(
  parameter int         NUM_OBJ   = 6,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_tick,
  input  logic [NUM_OBJ-1:0]   obj_valid,
  input  logic [8*NUM_OBJ-1:0] obj_x,
  input  logic [7*NUM_OBJ-1:0] obj_y,
  input  logic [5*NUM_OBJ-1:0] obj_w,
  input  logic [5*NUM_OBJ-1:0] obj_h,
  input  logic [3*NUM_OBJ-1:0] obj_c,
  output logic                 rect_start,
  output logic [7:0]           rect_x,
  output logic [6:0]           rect_y,
  output logic [4:0]           rect_w,
  output logic [4:0]           rect_h,
  output logic [2:0]           rect_c,
  input  logic                 rect_done,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);
  localparam int IW = $clog2(NUM_OBJ);
`ifdef DRAW_ERASE_EN
  typedef enum logic [2:0] {IDLE, ERASE_SCAN, ERASE_WAIT, DRAW_SCAN, DRAW_WAIT, COMMIT} state_t;
  localparam state_t FIRST = ERASE_SCAN;
`else
  typedef enum logic [2:0] {IDLE, DRAW_SCAN, DRAW_WAIT, COMMIT} state_t;
  localparam state_t FIRST = DRAW_SCAN;
`endif
  state_t state_q, state_d, scan_st, wait_st;
  logic [IW-1:0] idx_q, idx_d;
  logic [27:0] rect_q, rect_d;
  logic start_q, start_d, done_q, done_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [NUM_OBJ-1:0] nv_q, sv;
  logic [8*NUM_OBJ-1:0] nx_q, sx;
  logic [7*NUM_OBJ-1:0] ny_q, sy;
  logic [5*NUM_OBJ-1:0] nw_q, nh_q, sw, sh;
  logic [3*NUM_OBJ-1:0] nc_q;
  logic erase, elig, last;
  logic [7:0] x;
  logic [6:0] y;
  logic [4:0] w, h;
  logic [2:0] c;
`ifdef DRAW_ERASE_EN
  logic [NUM_OBJ-1:0] ov_q;
  logic [8*NUM_OBJ-1:0] ox_q;
  logic [7*NUM_OBJ-1:0] oy_q;
  logic [5*NUM_OBJ-1:0] ow_q, oh_q;
  assign erase = state_q == ERASE_SCAN || state_q == ERASE_WAIT;
  assign scan_st = erase ? ERASE_SCAN : DRAW_SCAN;
  assign wait_st = erase ? ERASE_WAIT : DRAW_WAIT;
  assign {sv, sx, sy, sw, sh} = erase ? {ov_q, ox_q, oy_q, ow_q, oh_q} : {nv_q, nx_q, ny_q, nw_q, nh_q};
`else
  assign erase = 1'b0;
  assign scan_st = DRAW_SCAN;
  assign wait_st = DRAW_WAIT;
  assign {sv, sx, sy, sw, sh} = {nv_q, nx_q, ny_q, nw_q, nh_q};
`endif
  // Both passes share one slot walker; erase selects old geometry and the background colour.
  assign x = sx[8*idx_q +: 8];
  assign y = sy[7*idx_q +: 7];
  assign w = sw[5*idx_q +: 5];
  assign h = sh[5*idx_q +: 5];
  assign c = erase ? BG_COLOUR : nc_q[3*idx_q +: 3];
  assign elig = sv[idx_q] && w != 5'd0 && h != 5'd0;
  assign last = idx_q == IW'(NUM_OBJ - 1);
  assign {rect_x, rect_y, rect_w, rect_h, rect_c} = rect_q;
  assign rect_start = start_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  assign overrun = ovr_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rect_d = rect_q;
    start_d = 1'b0;
    done_d = 1'b0;
    busy_d = busy_q;
    ovr_d = ovr_q || (frame_tick && busy_q);
    if (state_q == IDLE) begin
      if (frame_tick) begin
        idx_d = '0;
        busy_d = 1'b1;
        state_d = FIRST;
      end
    end else if (state_q == scan_st && elig) begin
      rect_d = {x, y, w, h, c};
      start_d = 1'b1;
      state_d = wait_st;
    end else if (state_q == scan_st || (state_q == wait_st && rect_done)) begin
      idx_d = last ? '0 : idx_q + 1'b1;
      state_d = last ? (erase ? DRAW_SCAN : COMMIT) : scan_st;
    end else if (state_q == COMMIT) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      rect_q <= '0;
      start_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ovr_q <= 1'b0;
      {nv_q, nx_q, ny_q, nw_q, nh_q, nc_q} <= '0;
`ifdef DRAW_ERASE_EN
      {ov_q, ox_q, oy_q, ow_q, oh_q} <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rect_q <= rect_d;
      start_q <= start_d;
      done_q <= done_d;
      busy_q <= busy_d;
      ovr_q <= ovr_d;
      if (state_q == IDLE && frame_tick) {nv_q, nx_q, ny_q, nw_q, nh_q, nc_q} <= {obj_valid, obj_x, obj_y, obj_w, obj_h, obj_c};
`ifdef DRAW_ERASE_EN
      if (state_q == COMMIT) {ov_q, ox_q, oy_q, ow_q, oh_q} <= {nv_q, nx_q, ny_q, nw_q, nh_q};
`endif
    end
  end
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: randomized frames checked by a scoreboard fed from a list-based frame model.
module tb_frame_draw_scheduler;
  localparam int N = 6;
`ifdef DRAW_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, frame_tick = 1'b0, rect_done = 1'b0;
  logic [N-1:0] obj_valid = '0;
  logic [8*N-1:0] obj_x = '0;
  logic [7*N-1:0] obj_y = '0;
  logic [5*N-1:0] obj_w = '0, obj_h = '0;
  logic [3*N-1:0] obj_c = '0;
  logic rect_start, busy, frame_done, overrun;
  logic [7:0] rect_x;
  logic [6:0] rect_y;
  logic [4:0] rect_w, rect_h;
  logic [2:0] rect_c;

  always #5 clk = ~clk;

  frame_draw_scheduler dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .obj_valid(obj_valid), .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h), .obj_c(obj_c),
    .rect_start(rect_start), .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h), .rect_c(rect_c),
    .rect_done(rect_done), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  int checks = 0, errors = 0, pending = 0, cnt = 0;
  logic [27:0] exp_q[$];
  logic       iv[N], ov[N];
  logic [7:0] ix[N], ox[N];
  logic [6:0] iy[N], oy[N];
  logic [4:0] iw[N], ih[N], ow[N], oh[N];
  logic [2:0] ic[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rect_start"}, rect_start, 0);
    chk({tag, "_rect"}, {rect_x, rect_y, rect_w, rect_h, rect_c}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < N; i++) begin
      iv[i] = 0; ix[i] = 0; iy[i] = 0; iw[i] = 0; ih[i] = 0; ic[i] = 0;
    end
  endtask

  task automatic random_slots();
    for (int i = 0; i < N; i++) begin
      iv[i] = 1'($urandom_range(0, 1));
      ix[i] = 8'($urandom);
      iy[i] = 7'($urandom);
      iw[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      ih[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      ic[i] = 3'($urandom);
    end
  endtask

  task automatic scramble();
    obj_valid = N'($urandom);
    for (int i = 0; i < N; i++) begin
      obj_x[8*i +: 8] = 8'($urandom); obj_y[7*i +: 7] = 7'($urandom);
      obj_w[5*i +: 5] = 5'($urandom); obj_h[5*i +: 5] = 5'($urandom); obj_c[3*i +: 3] = 3'($urandom);
    end
  endtask

  // Model: a frame is the list of old eligible rects in BG, then new eligible rects in their colour.
  task automatic start_frame();
    for (int i = 0; i < N; i++) begin
      obj_valid[i] = iv[i];
      obj_x[8*i +: 8] = ix[i]; obj_y[7*i +: 7] = iy[i];
      obj_w[5*i +: 5] = iw[i]; obj_h[5*i +: 5] = ih[i]; obj_c[3*i +: 3] = ic[i];
    end
    frame_tick = 1;
    if (ERASE)
      for (int i = 0; i < N; i++)
        if (ov[i] && ow[i] != 0 && oh[i] != 0) exp_q.push_back({ox[i], oy[i], ow[i], oh[i], 3'b000});
    for (int i = 0; i < N; i++)
      if (iv[i] && iw[i] != 0 && ih[i] != 0) exp_q.push_back({ix[i], iy[i], iw[i], ih[i], ic[i]});
    for (int i = 0; i < N; i++) begin
      ov[i] = iv[i]; ox[i] = ix[i]; oy[i] = iy[i]; ow[i] = iw[i]; oh[i] = ih[i];
    end
    pending++;
  endtask

  task automatic finish_frame(input bit timed, input int want, input bit ovr);
    int lat = 0;
    bit seen = 0, fire = ovr;
    while (!seen && lat < 3000) begin
      @(negedge clk);
      lat++;
      frame_tick = 0;
      if (frame_done) seen = 1;
      else begin
        if (fire && rect_start) begin frame_tick = 1; fire = 0; end
        scramble();
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got no frame_done expected one within 3000 cycles");
    end else begin
      if (timed) chk("frame_latency", lat, want);
      chk("busy_after_done", busy, 0);
    end
  endtask

  task automatic run_frame();
    start_frame();
    finish_frame(0, 0, 0);
  endtask

  initial begin : engine
    forever begin
      @(posedge clk);
      #2;
      rect_done = 0;
      if (!resetn) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) rect_done = 1;
      end else if (rect_start) cnt = $urandom_range(1, 12);
      else if ($urandom_range(0, 7) == 0) rect_done = 1;
    end
  end

  initial begin : monitor
    logic [27:0] cur;
    bit active;
    cur = '0;
    active = 0;
    forever begin
      @(negedge clk);
      if (!resetn) active = 0;
      else begin
        if (active) chk("rect_stable", {rect_x, rect_y, rect_w, rect_h, rect_c}, cur);
        if (active && rect_done) active = 0;
        if (rect_start) begin
          chk("busy_on_start", busy, 1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start: got rect %0h expected no rect_start", {rect_x, rect_y, rect_w, rect_h, rect_c});
          end else begin
            cur = exp_q.pop_front();
            chk("rect", {rect_x, rect_y, rect_w, rect_h, rect_c}, cur);
            active = 1;
          end
        end
        if (frame_done) begin
          chk("frame_expected", pending > 0, 1);
          chk("rects_left_at_done", exp_q.size(), 0);
          if (pending > 0) pending--;
        end
      end
    end
  end

  initial begin : stim
    int tries;
    clear_slots();
    for (int i = 0; i < N; i++) begin ov[i] = 0; ox[i] = 0; oy[i] = 0; ow[i] = 0; oh[i] = 0; end
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    resetn = 1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    start_frame();
    finish_frame(1, ERASE ? 14 : 8, 0);
    chk("no_overrun", overrun, 0);
    iv[0] = 1; ix[0] = 10; iy[0] = 20; iw[0] = 4; ih[0] = 3; ic[0] = 3'b100;
    run_frame();
    ix[0] = 11;
    run_frame();
    iv[2] = 1; ix[2] = 50; iy[2] = 60; iw[2] = 7; ih[2] = 2; ic[2] = 3'b010;
    iv[4] = 1; ix[4] = 90; iy[4] = 5; iw[4] = 0; ih[4] = 9; ic[4] = 3'b111;
    run_frame();
    iv[2] = 0;
    run_frame();
    repeat (25) begin
      random_slots();
      run_frame();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    chk("no_overrun_random", overrun, 0);
    random_slots();
    iv[0] = 1; iw[0] = 5; ih[0] = 6;
    start_frame();
    finish_frame(0, 0, 1);
    chk("overrun_set", overrun, 1);
    repeat (30) @(negedge clk);
    chk("overrun_sticky", overrun, 1);
    chk("no_extra_frame", busy, 0);
    random_slots();
    iv[5] = 1; iw[5] = 3; ih[5] = 3;
    start_frame();
    @(negedge clk);
    frame_tick = 0;
    tries = 0;
    while (!rect_start && tries < 500) begin @(negedge clk); tries++; end
    chk("start_before_reset", rect_start, 1);
    #3 resetn = 0;
    #1 check_zero("midframe_reset");
    exp_q.delete();
    pending = 0;
    for (int i = 0; i < N; i++) ov[i] = 0;
    repeat (3) @(negedge clk);
    resetn = 1;
    repeat (10) @(negedge clk);
    check_zero("after_release");
    run_frame();
    random_slots();
    run_frame();
    chk("final_pending", pending, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
